instr_fetch_unit: RTL and testbench

//  Fetch stage feeding the opcode decoder of the single-cycle core. Holds the PC, issues

---
 rtl/instr_fetch_unit_pkg.sv | 32 +++
 rtl/instr_fetch_unit_if.sv | 14 +
 rtl/instr_fetch_unit_pc_next_calc.sv | 19 +
 rtl/instr_fetch_unit.sv | 106 ++++++++++
 tb/tb_instr_fetch_unit.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: opcode values, instruction-register
// field positions and the fetch FSM state encoding.
package instr_fetch_unit_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_LW   = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_BNQ  = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;
    localparam logic [2:0] OP_SUB  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    // Field positions inside the 16-bit instruction word
    localparam int OPC_MSB = 15;
    localparam int RS_MSB  = 12;
    localparam int RS_LSB  = 10;
    localparam int RT_MSB  = 9;
    localparam int RT_LSB  = 7;
    localparam int RD_MSB  = 6;
    localparam int RD_LSB  = 4;
    localparam int IMM_MSB = 6;
    localparam int IMM_W   = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_EXEC = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read channel: request/address out of the fetch unit,
// single-cycle acknowledge with read data back from memory.
interface instr_fetch_unit_if #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16
);
    logic                   req;
    logic [PC_WIDTH-1:0]    addr;
    logic                   ack;
    logic [INSTR_WIDTH-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Combinational next-PC: sequential increment, or PC-relative branch when the
// decoder asks for a branch and the ALU result is non-zero (BNQ).
module pc_next_calc #(
    parameter int PC_WIDTH = 8
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [PC_WIDTH-1:0] imm_ext,
    input  logic                branch,
    input  logic                alu_zero,
    output logic [PC_WIDTH-1:0] pc_next
);
    logic taken;

    assign taken = branch && !alu_zero;

    // Truncation to PC_WIDTH gives the required modulo wrap in both directions
    assign pc_next = pc + PC_WIDTH'(1) + (taken ? imm_ext : '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, variable-latency instruction-memory handshake,
// instruction register with field decode, and next-PC update on retire.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                     PC_WIDTH     = 8,
    parameter int                     INSTR_WIDTH  = 16,
    parameter int                     DATA_WIDTH   = 16,
    parameter int                     OPCODE_WIDTH = 3,
    parameter logic [PC_WIDTH-1:0]    RESET_PC     = '0,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = OP_HALT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    instr_fetch_unit_if.master      imem,
    output logic                    instr_valid,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic [2:0]              rs,
    output logic [2:0]              rt,
    output logic [2:0]              rd,
    output logic [DATA_WIDTH-1:0]   imm_ext,
    input  logic                    instr_retire,
    input  logic                    branch,
    input  logic                    alu_zero,
    output logic [PC_WIDTH-1:0]     pc,
    output logic                    halted
);

    fetch_state_e           state_q;
    fetch_state_e           state_d;
    logic [INSTR_WIDTH-1:0] ir_q;
    logic [PC_WIDTH-1:0]    pc_q;
    logic [PC_WIDTH-1:0]    pc_next;
    logic                   is_halt;
    logic                   fetch_done;
    logic                   retire_done;

    assign is_halt     = (opcode == HALT_OPCODE);
    assign fetch_done  = (state_q == ST_REQ) && imem.ack;
    assign retire_done = (state_q == ST_EXEC) && instr_retire && !is_halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ:  if (imem.ack) state_d = ST_EXEC;
            // HALT wins over a retire pulse in the same cycle
            ST_EXEC: begin
                if (is_halt)           state_d = ST_HALT;
                else if (instr_retire) state_d = ST_REQ;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        imem.req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state_q)
            ST_REQ:  imem.req    = 1'b1;
            ST_EXEC: instr_valid = 1'b1;
            ST_HALT: halted      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q <= '0;
            pc_q <= RESET_PC;
        end else begin
            if (fetch_done)  ir_q <= imem.rdata;
            if (retire_done) pc_q <= pc_next;
        end
    end

    pc_next_calc #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next_calc (
        .pc       (pc_q),
        .imm_ext  (imm_ext[PC_WIDTH-1:0]),
        .branch   (branch),
        .alu_zero (alu_zero),
        .pc_next  (pc_next)
    );

    // Fields are a pure view of IR; instr_valid alone says whether they mean anything
    assign opcode    = ir_q[OPC_MSB -: OPCODE_WIDTH];
    assign rs        = ir_q[RS_MSB:RS_LSB];
    assign rt        = ir_q[RT_MSB:RT_LSB];
    assign rd        = ir_q[RD_MSB:RD_LSB];
    assign imm_ext   = {{(DATA_WIDTH-IMM_W){ir_q[IMM_MSB]}}, ir_q[IMM_MSB:0]};
    assign pc        = pc_q;
    assign imem.addr = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory handshake timing, branch/PC
// arithmetic including wrap, HALT behaviour and reset during a request.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [2:0]  opcode;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [15:0] imm_ext;
    logic        instr_retire;
    logic        branch;
    logic        alu_zero;
    logic [7:0]  pc;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_unit_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) imem ();

    instr_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem         (imem),
        .instr_valid  (instr_valid),
        .opcode       (opcode),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .imm_ext      (imm_ext),
        .instr_retire (instr_retire),
        .branch       (branch),
        .alu_zero     (alu_zero),
        .pc           (pc),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        imem.ack     = 1'b0;
        imem.rdata   = '0;
        instr_retire = 1'b0;
        branch       = 1'b0;
        alu_zero     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Wait for a request, stall `lat` cycles (with stray retire pulses), then ack with `word`
    task automatic fetch(input logic [15:0] word, input int lat);
        int         n = 0;
        logic [7:0] addr0;
        while (!imem.req && n < 20) begin
            tick();
            n++;
        end
        check("req_seen", imem.req, 1'b1);
        addr0 = imem.addr;
        check("addr_eq_pc", imem.addr, pc);
        for (int i = 0; i < lat; i++) begin
            instr_retire = 1'b1;
            branch       = 1'b1;
            tick();
            check("wait_req", imem.req, 1'b1);
            check("wait_addr", imem.addr, addr0);
            check("wait_valid", instr_valid, 1'b0);
        end
        instr_retire = 1'b0;
        branch       = 1'b0;
        imem.ack     = 1'b1;
        imem.rdata   = word;
        tick();
        imem.ack   = 1'b0;
        imem.rdata = 16'hA5A5;
        check("valid_after_ack", instr_valid, 1'b1);
        check("req_after_ack", imem.req, 1'b0);
    endtask

    task automatic retire(input logic br, input logic az, input logic [7:0] exp_pc);
        branch       = br;
        alu_zero     = az;
        instr_retire = 1'b1;
        tick();
        instr_retire = 1'b0;
        branch       = 1'b0;
        alu_zero     = 1'b0;
        check("pc_after_retire", pc, exp_pc);
        check("req_after_retire", imem.req, 1'b1);
        check("addr_after_retire", imem.addr, exp_pc);
        check("valid_after_retire", instr_valid, 1'b0);
    endtask

    initial begin
        // 1: reset values and zero-wait fetch
        apply_reset();
        check("rst_req", imem.req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_pc", pc, 8'h00);
        check("rst_opcode", opcode, 3'd0);
        check("rst_imm", imm_ext, 16'h0000);
        tick();
        check("cyc1_req", imem.req, 1'b1);
        fetch(16'h2000, 0);
        check("t1_opcode", opcode, 3'd1);
        check("t1_rs", rs, 3'd0);
        check("t1_pc", pc, 8'h00);
        retire(1'b0, 1'b0, 8'h01);

        // 2: five-cycle memory latency, taken branch to pc=10
        fetch(16'h8008, 5);
        check("t2_imm", imm_ext, 16'h0008);
        retire(1'b1, 1'b0, 8'h0A);

        // 3: negative offset taken, then not taken because alu_zero
        fetch(16'h807D, 0);
        check("t3_imm", imm_ext, 16'hFFFD);
        retire(1'b1, 1'b0, 8'h08);
        fetch(16'h8001, 0);
        retire(1'b1, 1'b0, 8'h0A);
        fetch(16'h807D, 0);
        retire(1'b1, 1'b1, 8'h0B);

        // 4: wrap at top of address space and negative wrap below zero
        fetch(16'h8073, 0);
        check("t4_imm", imm_ext, 16'hFFF3);
        retire(1'b1, 1'b0, 8'hFF);
        fetch(16'h1234, 0);
        check("t4_rs", rs, 3'd4);
        check("t4_rt", rt, 3'd4);
        check("t4_rd", rd, 3'd3);
        retire(1'b0, 1'b0, 8'h00);
        fetch(16'h0000, 0);
        retire(1'b0, 1'b0, 8'h01);
        fetch(16'h0000, 0);
        retire(1'b0, 1'b0, 8'h02);
        fetch(16'h807B, 0);
        retire(1'b1, 1'b0, 8'hFE);

        // 5: HALT opcode stops fetching for good
        fetch(16'hE000, 0);
        check("t5_opcode", opcode, 3'd7);
        check("t5_not_yet_halted", halted, 1'b0);
        tick();
        check("t5_halted", halted, 1'b1);
        check("t5_valid", instr_valid, 1'b0);
        for (int i = 0; i < 20; i++) begin
            instr_retire = i[0];
            imem.ack     = ~i[0];
            branch       = 1'b1;
            tick();
            check("t5_req_low", imem.req, 1'b0);
        end
        instr_retire = 1'b0;
        imem.ack     = 1'b0;
        branch       = 1'b0;
        check("t5_pc_frozen", pc, 8'hFE);
        check("t5_still_halted", halted, 1'b1);

        // 6: reset in the middle of a request, stray ack during reset/IDLE
        apply_reset();
        tick();
        fetch(16'h8004, 0);
        retire(1'b1, 1'b0, 8'h05);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_async_req", imem.req, 1'b0);
        check("t6_async_pc", pc, 8'h00);
        imem.ack   = 1'b1;
        imem.rdata = 16'hE000;
        tick();
        rst_n = 1'b1;
        check("t6_idle_req", imem.req, 1'b0);
        tick();
        imem.ack   = 1'b0;
        imem.rdata = 16'h0000;
        check("t6_req", imem.req, 1'b1);
        check("t6_addr", imem.addr, 8'h00);
        check("t6_valid", instr_valid, 1'b0);
        check("t6_opcode_clear", opcode, 3'd0);
        check("t6_halted", halted, 1'b0);
        fetch(16'h2000, 2);
        check("t6_opcode", opcode, 3'd1);
        retire(1'b0, 1'b0, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
